// File: rtl/imem_loader.sv
// imem_loader -- host-side program loader for the SIMD AES core's
// instruction memory.
//
// Accepts a framed byte stream (0xA5, LEN_HI, LEN_LO, 3*N instruction bytes,
// CHK), packs each byte triple MSB-first into a 21-bit instruction and writes
// it to consecutive instruction-memory addresses starting at 0. The core is
// held in reset from the frame's 0xA5 until the checksum has verified.
//
// Ports:
//   clk         core clock
//   rst         asynchronous, active-low reset
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader can accept a byte (low only in the write cycle)
//   imem_we     one-cycle write strobe per instruction
//   imem_addr   write address / write pointer
//   imem_wdata  instruction to write
//   core_hold   1 = keep the core in reset
//   load_done   last load completed and verified (level)
//   load_err    last load aborted (level)
module imem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [11:0] imem_addr,
  output logic [20:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA0,
    S_DATA1,
    S_DATA2,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        xfer;
  logic [3:0]  len_hi;
  logic [11:0] cnt;
  logic [7:0]  chk;
  logic [4:0]  b0;
  logic [7:0]  b1;
  logic [11:0] len_full;

  function automatic logic [20:0] pack_instr(input logic [4:0] hi,
                                             input logic [7:0] mid,
                                             input logic [7:0] lo);
    return {hi, mid, lo};
  endfunction

  assign in_ready = (state != S_WRITE);
  assign imem_we  = (state == S_WRITE);
  assign xfer     = in_valid && in_ready;
  assign len_full = {len_hi, in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (xfer && in_data == SYNC) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_nxt = (in_data[7:4] != 4'd0) ? S_ERR : S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) state_nxt = (len_full == 12'd0) ? S_ERR : S_DATA0;
      end
      S_DATA0: begin
        if (xfer) state_nxt = (in_data[7:5] != 3'd0) ? S_ERR : S_DATA1;
      end
      S_DATA1: begin
        if (xfer) state_nxt = S_DATA2;
      end
      S_DATA2: begin
        if (xfer) state_nxt = S_WRITE;
      end
      // Counter still holds the pre-decrement value here, so 1 means this
      // write is the last one.
      S_WRITE: begin
        state_nxt = (cnt == 12'd1) ? S_CHECK : S_DATA0;
      end
      S_CHECK: begin
        if (xfer) state_nxt = (in_data == chk) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_addr  <= 12'd0;
      imem_wdata <= 21'd0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      len_hi     <= 4'd0;
      cnt        <= 12'd0;
      chk        <= 8'd0;
      b0         <= 5'd0;
      b1         <= 8'd0;
    end else begin
      if (state == S_WRITE) begin
        imem_addr <= imem_addr + 12'd1;
        cnt       <= cnt - 12'd1;
      end
      if (xfer) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (in_data == SYNC) begin
              load_done <= 1'b0;
              load_err  <= 1'b0;
              chk       <= 8'd0;
              imem_addr <= 12'd0;
              core_hold <= 1'b1;
            end
          end
          S_LEN_HI: begin
            chk <= chk ^ in_data;
            if (in_data[7:4] != 4'd0) load_err <= 1'b1;
            else                      len_hi   <= in_data[3:0];
          end
          S_LEN_LO: begin
            chk <= chk ^ in_data;
            if (len_full == 12'd0) load_err <= 1'b1;
            else                   cnt      <= len_full;
          end
          S_DATA0: begin
            chk <= chk ^ in_data;
            if (in_data[7:5] != 3'd0) load_err <= 1'b1;
            else                      b0       <= in_data[4:0];
          end
          S_DATA1: begin
            chk <= chk ^ in_data;
            b1  <= in_data;
          end
          S_DATA2: begin
            chk        <= chk ^ in_data;
            imem_wdata <= pack_instr(b0, b1, in_data);
          end
          S_CHECK: begin
            if (in_data == chk) begin
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [20:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int rdy_bad = 0;
  bit gaps = 1'b0;

  logic [32:0] wq[$];
  logic [7:0]  frm[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and verify in_ready is low exactly on write cycles.
  always @(negedge clk) begin
    if (rst) begin
      if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
      if (in_ready !== ~imem_we) rdy_bad++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%02h", b);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
  endtask

  task automatic set_good_frame();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h1F, 8'hFF, 8'hFF, 8'h7A};
  endtask

  task automatic check_good_result(input string tag);
    checks++;
    if (wq.size() !== 2) begin errors++; $display("FAIL %s wcount got %0d exp 2", tag, wq.size()); end
    else begin
      checks++;
      if (wq[0] !== {12'd0, 21'h012345}) begin errors++; $display("FAIL %s w0 got %h exp %h", tag, wq[0], {12'd0, 21'h012345}); end
      checks++;
      if (wq[1] !== {12'd1, 21'h1FFFFF}) begin errors++; $display("FAIL %s w1 got %h exp %h", tag, wq[1], {12'd1, 21'h1FFFFF}); end
    end
    checks++;
    if ({load_done, load_err, core_hold} !== 3'b100) begin errors++; $display("FAIL %s flags done/err/hold got %b exp 100", tag, {load_done, load_err, core_hold}); end
    checks++;
    if (imem_addr !== 12'd2) begin errors++; $display("FAIL %s addr got %0d exp 2", tag, imem_addr); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, imem_we, core_hold, load_done, load_err} !== 5'b10100) begin
      errors++; $display("FAIL reset ctl got %b exp 10100", {in_ready, imem_we, core_hold, load_done, load_err});
    end
    checks++;
    if (imem_addr !== 12'd0 || imem_wdata !== 21'd0) begin
      errors++; $display("FAIL reset addr/data got %h/%h exp 0/0", imem_addr, imem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    wq.delete();
    send_byte(8'hA5);
    checks++;
    if ({load_done, load_err, core_hold} !== 3'b001) begin errors++; $display("FAIL good a5 flags got %b exp 001", {load_done, load_err, core_hold}); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    // One cycle after the third byte: write strobe with address 0.
    checks++;
    if ({imem_we, in_ready} !== 2'b10 || imem_addr !== 12'd0 || imem_wdata !== 21'h012345) begin
      errors++; $display("FAIL good wcycle we/rdy=%b addr=%0d data=%h exp 10/0/012345", {imem_we, in_ready}, imem_addr, imem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({imem_we, in_ready} !== 2'b01 || imem_addr !== 12'd1) begin
      errors++; $display("FAIL good postw we/rdy=%b addr=%0d exp 01/1", {imem_we, in_ready}, imem_addr);
    end
    send_byte(8'h1F); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h7A);
    check_good_result("good");
  endtask

  task automatic test_bad_checksum();
    wq.delete();
    set_good_frame();
    frm[9] = 8'h7B;
    send_frame();
    checks++;
    if (wq.size() !== 2) begin errors++; $display("FAIL badchk wcount got %0d exp 2", wq.size()); end
    checks++;
    if ({load_done, load_err, core_hold} !== 3'b011) begin errors++; $display("FAIL badchk flags got %b exp 011", {load_done, load_err, core_hold}); end
    checks++;
    if (imem_addr !== 12'd2) begin errors++; $display("FAIL badchk addr got %0d exp 2", imem_addr); end
  endtask

  task automatic test_format_errors();
    for (int t = 0; t < 3; t++) begin
      wq.delete();
      case (t)
        0: frm = '{8'hA5, 8'h00, 8'h00};
        1: frm = '{8'hA5, 8'h10, 8'h01};
        default: frm = '{8'hA5, 8'h00, 8'h01, 8'hE0};
      endcase
      send_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({load_done, load_err, core_hold} !== 3'b011) begin errors++; $display("FAIL fmt%0d flags got %b exp 011", t, {load_done, load_err, core_hold}); end
      checks++;
      if (wq.size() !== 0) begin errors++; $display("FAIL fmt%0d wcount got %0d exp 0", t, wq.size()); end
    end
  endtask

  task automatic test_back_to_back();
    for (int g = 0; g < 2; g++) begin
      wq.delete();
      rdy_bad = 0;
      gaps = (g == 1);
      set_good_frame();
      send_frame();
      gaps = 1'b0;
      check_good_result(g == 0 ? "b2b" : "gaps");
      checks++;
      if (rdy_bad !== 0) begin errors++; $display("FAIL hs%0d ready/we disagree cycles got %0d exp 0", g, rdy_bad); end
    end
  endtask

  task automatic test_reset_mid();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01};
    send_frame();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_we, core_hold, load_done, load_err} !== 5'b10100 || imem_addr !== 12'd0 || imem_wdata !== 21'd0) begin
      errors++; $display("FAIL rstmid got %b addr=%0d data=%h exp 10100/0/0", {in_ready, imem_we, core_hold, load_done, load_err}, imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wq.delete();
    set_good_frame();
    send_frame();
    check_good_result("rstmid_reload");
  endtask

  task automatic test_reload();
    wq.delete();
    send_byte(8'h00); send_byte(8'hFF);
    checks++;
    if ({load_done, core_hold} !== 2'b10 || wq.size() !== 0) begin
      errors++; $display("FAIL junk done/hold got %b wcount %0d exp 10/0", {load_done, core_hold}, wq.size());
    end
    send_byte(8'hA5);
    checks++;
    if ({load_done, load_err, core_hold} !== 3'b001 || imem_addr !== 12'd0) begin
      errors++; $display("FAIL reload a5 flags got %b addr %0d exp 001/0", {load_done, load_err, core_hold}, imem_addr);
    end
    set_good_frame();
    frm.delete(0);
    send_frame();
    check_good_result("reload");
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_format_errors();
    test_back_to_back();
    test_reset_mid();
    test_reload();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
